// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions for the sequential divider.
//   DIV_WIDTH     default operand/quotient/remainder width
//   div_state_t   divider FSM states (IDLE, CALC, FIN)
//   DIV0_QUOTIENT quotient reported for a zero divisor (all ones)
package arith_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// Ports:
//   rem      in  WIDTH  current partial remainder (always < divisor)
//   q        in  WIDTH  working quotient; its MSB is the next dividend bit
//   divisor  in  WIDTH  denominator
//   rem_next out WIDTH  partial remainder after this step
//   q_next   out WIDTH  q shifted left with the new quotient bit in the LSB
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  // The shifted remainder can reach 2*divisor-1, so it needs WIDTH+1 bits;
  // one more bit on the difference carries the borrow (sign).
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             neg;
  logic             unused_diff_bit;

  assign shifted  = {rem, q[WIDTH-1]};
  assign diff     = {1'b0, shifted} - {2'b00, divisor};
  assign neg      = diff[WIDTH+1];
  // A non-negative difference is below divisor, so it always fits WIDTH bits.
  assign unused_diff_bit = diff[WIDTH];
  assign rem_next = neg ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_next   = {q[WIDTH-2:0], ~neg};

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Optional macro SEQ_DIVIDER_SIGNED_EN: two's-complement operands with
// truncating division (magnitudes divided, signs fixed on the FIN entry edge).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        division request, accepted only while busy=0
//   dividend     numerator, sampled on the accept edge
//   divisor      denominator, sampled on the accept edge
//   busy         high from accept until done falls
//   done         one-cycle pulse in FIN, results valid
//   quotient     result quotient, held until the next result
//   remainder    result remainder, held until the next result
//   div_by_zero  set with done for a zero divisor, cleared on next accept
//   state_dbg    current FSM state for observation
// Handshake: start is a level request sampled at each edge in IDLE; a start
// seen while busy is dropped, never queued. done is exactly one cycle wide and
// is the last cycle of busy.
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output div_state_t       state_dbg
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       state, state_d;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_r, q_r, dvs_r;
  logic [WIDTH-1:0] step_rem, step_q;
  logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix;
  logic             divisor_zero;

  assign divisor_zero = (divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q, neg_r;
  // Magnitudes; the most-negative value maps onto itself, which is its
  // correct unsigned magnitude, so overflow needs no special case.
  assign mag_a = dividend[WIDTH-1] ? -dividend : dividend;
  assign mag_b = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign q_fix = neg_q ? -step_q   : step_q;
  assign r_fix = neg_r ? -step_rem : step_rem;
`else
  assign mag_a = dividend;
  assign mag_b = divisor;
  assign q_fix = step_q;
  assign r_fix = step_rem;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .q        (q_r),
    .divisor  (dvs_r),
    .rem_next (step_rem),
    .q_next   (step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start) state_d = divisor_zero ? FIN : CALC;
      CALC: if (count == LAST_CNT) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count       <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      dvs_r       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem_r       <= '0;
            q_r         <= mag_a;
            dvs_r       <= mag_b;
            count       <= '0;
            div_by_zero <= divisor_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r       <= dividend[WIDTH-1];
`endif
            // Zero divisor skips CALC, so its results load here.
            if (divisor_zero) begin
              quotient  <= WIDTH'(DIV0_QUOTIENT);
              remainder <= dividend;
            end
          end
        end
        CALC: begin
          rem_r <= step_rem;
          q_r   <= step_q;
          count <= count + CNT_W'(1);
          if (count == LAST_CNT) begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
  import arith_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  div_state_t   state_dbg;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [2*W:0] exp_q[$];

  seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: compare every done pulse against the oldest expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [2*W:0] e;
        e = exp_q.pop_front();
        chk("quotient", {32'd0, quotient}, {32'd0, e[2*W-1:W]});
        chk("remainder", {32'd0, remainder}, {32'd0, e[W-1:0]});
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e[2*W]});
      end
    end
  end

  // driver: one division, with latency and busy-window checks
  task automatic run_div(input vec_t v, input string name);
    int cyc;
    @(negedge clk);
    dividend = v.a;
    divisor  = v.b;
    start    = 1'b1;
    exp_q.push_back({v.dz, v.q, v.r});
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({name, "_busy_after_accept"}, {63'd0, busy}, 64'd1);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!done) chk({name, "_busy_mid"}, {63'd0, busy}, 64'd1);
    end
    chk({name, "_latency"}, cyc, v.dz ? 64'd1 : 64'd33);
    @(negedge clk);
    chk({name, "_busy_low_after"}, {63'd0, busy}, 64'd0);
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_quotient", {32'd0, quotient}, 64'd0);
    chk("rst_remainder", {32'd0, remainder}, 64'd0);
    chk("rst_dz", {63'd0, div_by_zero}, 64'd0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs[0] = '{32'd252,        32'd21,         32'd12,         32'd0,          1'b0};
    vecs[1] = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
    vecs[2] = '{32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0};
    vecs[3] = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[4] = '{32'hDEADBEEF,   32'd0,          32'hFFFFFFFF,   32'hDEADBEEF,   1'b1};
    vecs[5] = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[6] = '{32'd5,          32'hFFFFFFF7,   32'd0,          32'd5,          1'b0};
    vecs[7] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
`else
    vecs[0] = '{32'd252,        32'd21,         32'd12,         32'd0,          1'b0};
    vecs[1] = '{32'd25200,      32'd8,          32'd3150,       32'd0,          1'b0};
    vecs[2] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[3] = '{32'hDEADBEEF,   32'd0,          32'hFFFFFFFF,   32'hDEADBEEF,   1'b1};
    vecs[4] = '{32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
    vecs[5] = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[6] = '{32'hFFFFFFFF,   32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b0};
    vecs[7] = '{32'h80000000,   32'h80000001,   32'd0,          32'h80000000,   1'b0};
`endif
    for (int i = 0; i < 8; i++) run_div(vecs[i], $sformatf("vec%0d", i));

    // random operands against the language's own division operators
    for (int i = 0; i < 6; i++) begin
      v.a = $urandom();
      v.b = $urandom_range(1, 70000);
      v.dz = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      if (i[0]) v.b = -v.b;
      v.q = $signed(v.a) / $signed(v.b);
      v.r = $signed(v.a) % $signed(v.b);
`else
      v.q = v.a / v.b;
      v.r = v.a % v.b;
`endif
      run_div(v, $sformatf("rand%0d", i));
    end

    // start while busy is ignored
    begin
      int base, cyc;
      base = done_cnt;
      @(negedge clk);
      dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
      exp_q.push_back({1'b0, 32'd100, 32'd0});
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      dividend = 32'd9; divisor = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 40) begin @(negedge clk); cyc++; end
      chk("busy_start_done_seen", {63'd0, done}, 64'd1);
      repeat (40) @(negedge clk);
      chk("busy_start_single_done", done_cnt - base, 64'd1);
      chk("busy_start_queue_empty", exp_q.size(), 64'd0);
    end

    // reset mid-operation abandons the division
    begin
      int base;
      base = done_cnt;
      @(negedge clk);
      dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_done", {63'd0, done}, 64'd0);
      chk("midrst_quotient", {32'd0, quotient}, 64'd0);
      chk("midrst_remainder", {32'd0, remainder}, 64'd0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("midrst_no_done", done_cnt - base, 64'd0);
      v = '{32'd7, 32'd2, 32'd3, 32'd1, 1'b0};
      run_div(v, "after_rst");
    end

    // start held high through FIN is accepted again at the first IDLE edge
    begin
      int cyc;
      @(negedge clk);
      dividend = 32'd50; divisor = 32'd0; start = 1'b1;
      exp_q.push_back({1'b1, 32'hFFFFFFFF, 32'd50});
      @(negedge clk);
      chk("held_start_fin", {63'd0, done}, 64'd1);
      exp_q.push_back({1'b1, 32'hFFFFFFFF, 32'd50});
      @(negedge clk);
      chk("held_start_idle", {63'd0, busy}, 64'd0);
      @(negedge clk);
      start = 1'b0;
      chk("held_start_second_done", {63'd0, done}, 64'd1);
      cyc = 0;
      while (busy && cyc < 5) begin @(negedge clk); cyc++; end
      chk("final_queue_empty", exp_q.size(), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
